// File: rtl/os_edge_feeder.sv
// Edge injector for the output-stationary PE array: buffers k-slices, tags tile starts
// with clr, and skews lane i by i cycles before it reaches the array edge.
module os_edge_feeder #(
    parameter int unsigned IP_size    = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned K_MAX      = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*IP_size-1:0] s_data,
    input  logic                     s_last,
    input  logic                     hold,
    output logic [LANES*IP_size-1:0] x_out,
    output logic [LANES-1:0]         en_out,
    output logic [LANES-1:0]         clr_out,
    output logic                     tile_done,
    output logic [15:0]              tiles_done,
    output logic                     len_err
);
    localparam int unsigned DATA_W = LANES * IP_size;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned K_W    = $clog2(K_MAX + 1);

    typedef struct packed {
        logic [IP_size-1:0] x;
        logic               en;
        logic               clr;
        logic               last;
    } tok_t;

    logic [DATA_W:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  head_data;
    logic               head_last;

    logic               first_flag;
    logic [K_W-1:0]     k_cnt;

    logic               drain_en;
    logic               drain_last;

    assign push = s_valid && s_ready;
    assign pop  = (count != '0) && !hold;
    assign {head_data, head_last} = mem[rd_ptr];

    // Occupancy after this edge; also drives the registered s_ready.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_data, s_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            s_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // Tile framing: an overlong tile is force-closed so the next beat restarts accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_flag <= 1'b1;
            k_cnt      <= '0;
            len_err    <= 1'b0;
        end else if (pop) begin
            if (head_last) begin
                first_flag <= 1'b1;
                k_cnt      <= '0;
            end else if (k_cnt == K_W'(K_MAX - 1)) begin
                first_flag <= 1'b1;
                k_cnt      <= '0;
                len_err    <= 1'b1;
            end else begin
                first_flag <= 1'b0;
                k_cnt      <= k_cnt + K_W'(1);
            end
        end
    end

    // Per lane: chain[0] is the issue register, chain[i] drives the array edge.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tok_t issue_tok;
        tok_t chain [0:i];

        always_comb begin
            issue_tok = '0;
            if (pop) begin
                issue_tok.x    = head_data[i*IP_size +: IP_size];
                issue_tok.en   = 1'b1;
                issue_tok.clr  = first_flag;
                issue_tok.last = head_last;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) begin
                    chain[j] <= '0;
                end
            end else begin
                chain[0] <= issue_tok;
                for (int j = 1; j <= i; j++) begin
                    chain[j] <= chain[j-1];
                end
            end
        end

        assign x_out[i*IP_size +: IP_size] = chain[i].x;
        assign en_out[i]                   = chain[i].en;
        assign clr_out[i]                  = chain[i].clr;

        if (i == LANES - 1) begin : g_drain
            if (i == 0) begin : g_single
                assign drain_en   = issue_tok.en;
                assign drain_last = issue_tok.last;
            end else begin : g_multi
                assign drain_en   = chain[i-1].en;
                assign drain_last = chain[i-1].last;
            end
        end
    end

    // Looks one stage ahead so the pulse lines up with the last lane's final element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_done  <= 1'b0;
            tiles_done <= '0;
        end else begin
            tile_done <= drain_en && drain_last;
            if (drain_en && drain_last) begin
                tiles_done <= tiles_done + 16'd1;
            end
        end
    end

endmodule
